// File: rtl/xcorr_peak_finder.sv
// xcorr_peak_finder: snapshots six cross-correlation arrays and scans them serially for each pair's peak lag
module xcorr_peak_finder #(
  parameter int NUM_BITS_XCORR = 32,
  parameter int MAX_SAMPLES_DELAY = 9,
  parameter int NUM_BITS_LAG = 5,
  localparam int NUM_LAGS = 2 * MAX_SAMPLES_DELAY + 1,
  localparam int W = NUM_LAGS * NUM_BITS_XCORR
) (
  input  logic clk,
  input  logic rst,
  input  logic validIn,
  input  logic [W-1:0] xCorrIn0,
  input  logic [W-1:0] xCorrIn1,
  input  logic [W-1:0] xCorrIn2,
  input  logic [W-1:0] xCorrIn3,
  input  logic [W-1:0] xCorrIn4,
  input  logic [W-1:0] xCorrIn5,
  output logic validOut,
  output logic signed [NUM_BITS_LAG-1:0] lagOut0,
  output logic signed [NUM_BITS_LAG-1:0] lagOut1,
  output logic signed [NUM_BITS_LAG-1:0] lagOut2,
  output logic signed [NUM_BITS_LAG-1:0] lagOut3,
  output logic signed [NUM_BITS_LAG-1:0] lagOut4,
  output logic signed [NUM_BITS_LAG-1:0] lagOut5,
  output logic busy,
  output logic overrun
);
  localparam int CW = $clog2(NUM_LAGS);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;
  logic [0:0] state;
  logic [CW-1:0] cnt;
  logic [W-1:0] xin [6];
  logic signed [NUM_BITS_XCORR-1:0] snap [6][NUM_LAGS];
  logic signed [NUM_BITS_XCORR-1:0] best_val [6];
  logic signed [NUM_BITS_XCORR-1:0] nxt_val [6];
  logic [CW-1:0] best_idx [6];
  logic [CW-1:0] nxt_idx [6];
  logic signed [NUM_BITS_LAG-1:0] lag_q [6];
  assign xin = '{xCorrIn0, xCorrIn1, xCorrIn2, xCorrIn3, xCorrIn4, xCorrIn5};
  assign busy = state == SCAN;
  assign lagOut0 = lag_q[0];
  assign lagOut1 = lag_q[1];
  assign lagOut2 = lag_q[2];
  assign lagOut3 = lag_q[3];
  assign lagOut4 = lag_q[4];
  assign lagOut5 = lag_q[5];
  // per-pair running maximum including the lag at the current counter; strict compare keeps the lowest index on ties
  always_comb begin
    for (int p = 0; p < 6; p++) begin
      nxt_val[p] = snap[p][cnt] > best_val[p] ? snap[p][cnt] : best_val[p];
      nxt_idx[p] = snap[p][cnt] > best_val[p] ? cnt : best_idx[p];
    end
  end
  // control: state, lag counter, completion pulse, published lags and sticky overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      validOut <= 1'b0;
      overrun <= 1'b0;
      for (int p = 0; p < 6; p++) lag_q[p] <= '0;
    end else begin
      validOut <= 1'b0;
      if (state == IDLE) begin
        if (validIn) begin
          cnt <= CW'(1);
          state <= SCAN;
        end
      end else begin
        if (validIn) overrun <= 1'b1;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(NUM_LAGS - 1)) begin
          for (int p = 0; p < 6; p++)
            lag_q[p] <= NUM_BITS_LAG'(nxt_idx[p]) - NUM_BITS_LAG'(MAX_SAMPLES_DELAY);
          validOut <= 1'b1;
          state <= IDLE;
          cnt <= '0;
        end
      end
    end
  end
  // datapath: snapshot capture on acceptance, running best value/index during the scan
  always_ff @(posedge clk) begin
    if (state == IDLE && validIn) begin
      for (int p = 0; p < 6; p++) begin
        for (int k = 0; k < NUM_LAGS; k++)
          snap[p][k] <= $signed(xin[p][k*NUM_BITS_XCORR +: NUM_BITS_XCORR]);
        best_val[p] <= $signed(xin[p][NUM_BITS_XCORR-1:0]);
        best_idx[p] <= '0;
      end
    end else if (state == SCAN) begin
      for (int p = 0; p < 6; p++) begin
        best_val[p] <= nxt_val[p];
        best_idx[p] <= nxt_idx[p];
      end
    end
  end
endmodule

// File: tb/tb_xcorr_peak_finder.sv
// tb_xcorr_peak_finder: directed self-checking bench for xcorr_peak_finder
module tb_xcorr_peak_finder;
  logic clk = 1'b0;
  logic rst;
  logic valid_in;
  logic [607:0] xin [6];
  logic valid_out, busy, overrun;
  logic signed [4:0] lag [6];
  int checks = 0;
  int failures = 0;
  int lat, pulses, busy_cnt;
  xcorr_peak_finder dut (
    .clk(clk), .rst(rst), .validIn(valid_in),
    .xCorrIn0(xin[0]), .xCorrIn1(xin[1]), .xCorrIn2(xin[2]),
    .xCorrIn3(xin[3]), .xCorrIn4(xin[4]), .xCorrIn5(xin[5]),
    .validOut(valid_out),
    .lagOut0(lag[0]), .lagOut1(lag[1]), .lagOut2(lag[2]),
    .lagOut3(lag[3]), .lagOut4(lag[4]), .lagOut5(lag[5]),
    .busy(busy), .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic setv(input int p, input int k, input logic [31:0] v);
    xin[p][k*32 +: 32] = v;
  endtask
  task automatic fill(input int p, input logic [31:0] v);
    for (int k = 0; k < 19; k++) xin[p][k*32 +: 32] = v;
  endtask
  task automatic clear_all();
    for (int p = 0; p < 6; p++) xin[p] = '0;
  endtask
  task automatic start();
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    busy_cnt = busy ? 1 : 0;
  endtask
  task automatic wait_done(output int l);
    l = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (valid_out) begin
        l = i;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask
  initial begin
    rst = 1'b1;
    valid_in = 1'b0;
    clear_all();
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", valid_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_lag0", lag[0], 0);
    chk("rst_lag5", lag[5], 0);
    setv(0, 12, 1000);
    start();
    wait_done(lat);
    chk("t1_latency", lat, 18);
    chk("t1_busy_cycles", busy_cnt, 18);
    chk("t1_busy_done", busy, 0);
    chk("t1_lag0", lag[0], 3);
    for (int p = 1; p < 6; p++) chk($sformatf("t1_lag%0d", p), lag[p], -9);
    step();
    chk("t1_valid_one_cycle", valid_out, 0);
    chk("t1_lag0_hold", lag[0], 3);
    clear_all();
    fill(1, -5);
    setv(1, 4, -1);
    setv(1, 10, -1);
    fill(2, -2);
    setv(2, 0, 32'h8000_0000);
    start();
    wait_done(lat);
    chk("t2_latency", lat, 18);
    chk("t2_lag0", lag[0], -9);
    chk("t2_lag1_tie", lag[1], -5);
    chk("t2_lag2_signed", lag[2], -8);
    step();
    clear_all();
    setv(3, 18, 32'h7FFF_FFFF);
    fill(4, 4);
    setv(4, 0, 5);
    start();
    wait_done(lat);
    chk("t3_latency", lat, 18);
    chk("t3_lag3_last", lag[3], 9);
    chk("t3_lag4_first", lag[4], -9);
    step();
    clear_all();
    setv(5, 7, 50);
    start();
    setv(5, 15, 999);
    wait_done(lat);
    chk("t4_latency", lat, 18);
    chk("t4_lag5_isolated", lag[5], -2);
    step();
    clear_all();
    setv(0, 5, 7);
    setv(1, 2, 3);
    start();
    pulses = 0;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (valid_out) pulses++;
    end
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    if (valid_out) pulses++;
    chk("t5_overrun_set", overrun, 1);
    chk("t5_busy_after_drop", busy, 1);
    for (int i = 6; i <= 17; i++) begin
      step();
      if (valid_out) pulses++;
    end
    valid_in = 1'b1;
    step();
    chk("t5_no_early_pulse", pulses, 0);
    chk("t5_valid_e18", valid_out, 1);
    chk("t5_lag0", lag[0], -4);
    chk("t5_lag1", lag[1], -7);
    chk("t5_overrun_sticky", overrun, 1);
    step();
    valid_in = 1'b0;
    chk("t5_single_pulse", valid_out, 0);
    chk("t5_b2b_busy", busy, 1);
    busy_cnt = 1;
    wait_done(lat);
    chk("t5_b2b_latency", lat, 18);
    chk("t5_b2b_lag0", lag[0], -4);
    chk("t5_overrun_still", overrun, 1);
    step();
    clear_all();
    setv(2, 9, 77);
    start();
    for (int i = 1; i <= 9; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_overrun", overrun, 0);
    chk("t6_rst_lag0", lag[0], 0);
    chk("t6_rst_lag2", lag[2], 0);
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      if (valid_out) pulses++;
      step();
    end
    chk("t6_no_pulse", pulses, 0);
    clear_all();
    setv(3, 14, 123);
    start();
    wait_done(lat);
    chk("t6_latency", lat, 18);
    chk("t6_lag3", lag[3], 5);
    chk("t6_lag2", lag[2], -9);
    chk("t6_overrun_clear", overrun, 0);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
